// File: rtl/bird_pkg.sv
// Shared types and default constants for the bird vertical-motion engine.
package bird_pkg;

  typedef enum logic [1:0] {IDLE, FLY, DEAD} bird_state_t;

  localparam int BIRD_ROWS      = 16;
  localparam int BIRD_START_ROW = 8;
  localparam int BIRD_GRAVITY   = 1;
  localparam int BIRD_MAX_FALL  = 3;
  localparam int BIRD_FLAP_VEL  = 3;
  localparam int BIRD_VEL_W     = 5;

  // Velocity add that saturates at the terminal fall speed.
  function automatic int sat_add(input int vel, input int inc, input int hi);
    int sum;
    sum = vel + inc;
    return (sum > hi) ? hi : sum;
  endfunction

endpackage

// File: rtl/bird_physics_rise_edge.sv
// Rising-edge detector with a registered history bit; rise is valid in the same cycle as the input edge.
module rise_edge (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  always_ff @(posedge clk) begin
    if (reset) sig_q <= 1'b0;
    else       sig_q <= sig;
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/bird_physics.sv
// Bird vertical motion and IDLE/FLY/DEAD play-state FSM.
// BIRD_CEILING_KILL_EN: hitting the ceiling kills the bird instead of clamping at row 0.
module bird_physics
  import bird_pkg::*;
#(
  parameter int ROWS      = BIRD_ROWS,
  parameter int ROW_W     = 4,
  parameter int START_ROW = BIRD_START_ROW,
  parameter int GRAVITY   = BIRD_GRAVITY,
  parameter int MAX_FALL  = BIRD_MAX_FALL,
  parameter int FLAP_VEL  = BIRD_FLAP_VEL,
  parameter int VEL_W     = BIRD_VEL_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    flap,
  input  logic                    collide,
  input  logic                    restart,
  output logic [ROW_W-1:0]        bird_y,
  output logic signed [VEL_W-1:0] bird_vel,
  output logic                    playing,
  output logic                    dead
);

  localparam logic signed [ROW_W+1:0] FLOOR = (ROW_W+2)'(ROWS - 1);

  bird_state_t              state;
  logic                     flap_pending;
  logic                     flap_rise;
  logic                     eff_flap;
  logic signed [VEL_W-1:0]  v_next;
  logic signed [ROW_W+1:0]  y_next;

  rise_edge u_flap_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (flap),
    .rise  (flap_rise)
  );

  // Position is computed two bits wider and signed so both floor and ceiling overshoot are visible.
  always_comb begin
    eff_flap = flap_pending | flap_rise;
    v_next   = eff_flap ? VEL_W'(-FLAP_VEL)
                        : VEL_W'(sat_add(int'(bird_vel), GRAVITY, MAX_FALL));
    y_next   = $signed({2'b00, bird_y}) + (ROW_W+2)'(v_next);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      bird_y       <= ROW_W'(START_ROW);
      bird_vel     <= '0;
      flap_pending <= 1'b0;
      playing      <= 1'b0;
      dead         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bird_y       <= ROW_W'(START_ROW);
          bird_vel     <= '0;
          flap_pending <= 1'b0;
          if (flap_rise) begin
            state   <= FLY;
            playing <= 1'b1;
          end
        end
        FLY: begin
          if (collide) begin
            state        <= DEAD;
            playing      <= 1'b0;
            dead         <= 1'b1;
            flap_pending <= 1'b0;
          end else if (tick) begin
            flap_pending <= 1'b0;
            if (y_next >= FLOOR) begin
              bird_y   <= ROW_W'(ROWS - 1);
              bird_vel <= '0;
              state    <= DEAD;
              playing  <= 1'b0;
              dead     <= 1'b1;
            end else if (y_next[ROW_W+1]) begin
              bird_y   <= '0;
              bird_vel <= '0;
`ifdef BIRD_CEILING_KILL_EN
              state    <= DEAD;
              playing  <= 1'b0;
              dead     <= 1'b1;
`endif
            end else begin
              bird_y   <= y_next[ROW_W-1:0];
              bird_vel <= v_next;
            end
          end else if (flap_rise) begin
            flap_pending <= 1'b1;
          end
        end
        DEAD: begin
          if (restart) begin
            state        <= IDLE;
            bird_y       <= ROW_W'(START_ROW);
            bird_vel     <= '0;
            flap_pending <= 1'b0;
            dead         <= 1'b0;
            playing      <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          playing <= 1'b0;
          dead    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bird_physics.sv
// Directed bench for bird_physics with hand-computed expected rows and velocities.
module tb_bird_physics;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              tick = 1'b0;
  logic              flap = 1'b0;
  logic              collide = 1'b0;
  logic              restart = 1'b0;
  logic [3:0]        bird_y;
  logic signed [4:0] bird_vel;
  logic              playing;
  logic              dead;

  int errors = 0;
  int checks = 0;

  bird_physics dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .flap     (flap),
    .collide  (collide),
    .restart  (restart),
    .bird_y   (bird_y),
    .bird_vel (bird_vel),
    .playing  (playing),
    .dead     (dead)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic start_flight();
    flap = 1'b1;
    step();
    flap = 1'b0;
    step();
  endtask

  task automatic flap_tick();
    flap = 1'b1;
    tick = 1'b1;
    step();
    flap = 1'b0;
    tick = 1'b0;
    step();
  endtask

  task automatic do_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
  endtask

  task automatic expect_yv(input string tag, input int y, input int v);
    check({tag, "_y"}, int'(bird_y), y);
    check({tag, "_vel"}, int'(bird_vel), v);
  endtask

  int exp_y[10] = '{5, 3, 2, 2, 3, 5, 8, 11, 14, 15};
  int exp_v[10] = '{-3, -2, -1, 0, 1, 2, 3, 3, 3, 0};

  initial begin
    step();
    step();
    reset = 1'b0;
    expect_yv("reset", 8, 0);
    check("reset_playing", int'(playing), 0);
    check("reset_dead", int'(dead), 0);

    do_tick();
    check("idle_tick_y", int'(bird_y), 8);
    do_restart();
    check("idle_restart_playing", int'(playing), 0);

    start_flight();
    check("start_playing", int'(playing), 1);
    expect_yv("start", 8, 0);

    // Free fall.
    do_tick(); expect_yv("fall1", 9, 1);
    do_tick(); expect_yv("fall2", 11, 2);
    do_tick(); expect_yv("fall3", 14, 3);
    do_tick(); expect_yv("fall4", 15, 0);
    check("fall_dead", int'(dead), 1);
    check("fall_playing", int'(playing), 0);
    do_tick(); check("dead_tick_y", int'(bird_y), 15);
    flap_tick(); check("dead_flap_y", int'(bird_y), 15);

    do_restart();
    expect_yv("restart", 8, 0);
    check("restart_playing", int'(playing), 0);
    check("restart_dead", int'(dead), 0);

    // Flap arc, with the flap registered as pending before the tick.
    start_flight();
    flap = 1'b1; step(); flap = 1'b0; step();
    check("pending_no_move", int'(bird_y), 8);
    do_tick(); expect_yv("arc1", 5, -3);
    do_tick(); expect_yv("arc2", 3, -2);
    do_tick(); expect_yv("arc3", 2, -1);
    do_tick(); expect_yv("arc4", 2, 0);
    do_tick(); expect_yv("arc5", 3, 1);
    collide = 1'b1; step(); collide = 1'b0;
    check("collide_dead", int'(dead), 1);
    do_restart();

    // Ceiling.
    start_flight();
    flap_tick(); expect_yv("ceil_a", 5, -3);
    do_tick();   expect_yv("ceil_b", 3, -2);
    do_tick();   expect_yv("ceil_c", 2, -1);
    flap_tick(); expect_yv("ceil_hit", 0, 0);
`ifdef BIRD_CEILING_KILL_EN
    check("ceil_dead", int'(dead), 1);
`else
    check("ceil_playing", int'(playing), 1);
    do_tick(); expect_yv("ceil_resume", 1, 1);
    collide = 1'b1; step(); collide = 1'b0;
`endif
    do_restart();
    step();

    // Collision has priority over a same-cycle tick.
    start_flight();
    do_tick();   expect_yv("col_a", 9, 1);
    flap_tick(); expect_yv("col_b", 6, -3);
    collide = 1'b1; tick = 1'b1; step(); collide = 1'b0; tick = 1'b0;
    check("col_dead", int'(dead), 1);
    expect_yv("col_freeze", 6, -3);
    do_tick();
    flap_tick();
    check("col_after_y", int'(bird_y), 6);

    // A flap held across restart must not start a flight.
    flap = 1'b1; step();
    do_restart();
    check("held_restart_dead", int'(dead), 0);
    step(); step();
    check("held_no_start", int'(playing), 0);
    flap = 1'b0; step();

    // Reset mid-flight overrides all inputs.
    start_flight();
    flap_tick();
    do_tick();
    check("pre_reset_y", int'(bird_y), 3);
    reset = 1'b1; flap = 1'b1; tick = 1'b1; collide = 1'b1;
    step();
    reset = 1'b0; flap = 1'b0; tick = 1'b0; collide = 1'b0;
    expect_yv("mid_reset", 8, 0);
    check("mid_reset_playing", int'(playing), 0);
    check("mid_reset_dead", int'(dead), 0);
    step();

    // Held flap applies only once.
    start_flight();
    flap = 1'b1;
    for (int i = 0; i < 10; i++) begin
      do_tick();
      expect_yv($sformatf("hold%0d", i), exp_y[i], exp_v[i]);
      step();
    end
    flap = 1'b0;
    check("hold_dead", int'(dead), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
